// File: rtl/dec_pipe.sv
// rtl/dec_pipe.sv - registered decode stage with register file, load-use interlock, flush and bypass

module dec_ctrl (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [1:0] regdst,
    output logic       shiftsel,
    output logic       immsize,
    output logic       unsgnsel,
    output logic       branch,
    output logic       jump,
    output logic       memread,
    output logic       memtoreg,
    output logic       aluop,
    output logic       mulop,
    output logic       memwrite,
    output logic       alusrc,
    output logic       regwrite,
    output logic [5:0] alufunc
);
    always_comb begin
        regdst   = 2'b00;
        shiftsel = 1'b0;
        immsize  = 1'b0;
        unsgnsel = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        memread  = 1'b0;
        memtoreg = 1'b0;
        aluop    = 1'b0;
        mulop    = 1'b0;
        memwrite = 1'b0;
        alusrc   = 1'b0;
        regwrite = 1'b0;
        alufunc  = 6'h00;
        case (opcode)
            6'h00: begin
                regdst   = 2'b01;
                regwrite = 1'b1;
                aluop    = 1'b1;
                alufunc  = funct;
                mulop    = (funct == 6'h18) || (funct == 6'h19);
            end
            6'h02: begin
                jump    = 1'b1;
                immsize = 1'b1;
            end
            6'h03: begin
                jump     = 1'b1;
                immsize  = 1'b1;
                regdst   = 2'b10;
                regwrite = 1'b1;
            end
            6'h04, 6'h05: begin
                branch  = 1'b1;
                alufunc = 6'h22;
            end
            6'h08, 6'h09: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                alufunc  = (opcode == 6'h08) ? 6'h20 : 6'h21;
            end
            6'h0c, 6'h0d: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                unsgnsel = 1'b1;
                alufunc  = (opcode == 6'h0c) ? 6'h24 : 6'h25;
            end
            6'h0f: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                shiftsel = 1'b1;
                alufunc  = 6'h25;
            end
            6'h23: begin
                memread  = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
                alusrc   = 1'b1;
                alufunc  = 6'h20;
            end
            6'h2b: begin
                memwrite = 1'b1;
                alusrc   = 1'b1;
                alufunc  = 6'h20;
            end
            default: ;
        endcase
    end
endmodule

module dec_pipe #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     Instruction,
    input  logic [XLEN-1:0] PCAddrIncIn,
    input  logic            Flush,
    input  logic            RegWriteIn,
    input  logic [AW-1:0]   RAddrIn,
    input  logic [XLEN-1:0] RData,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] ImmData,
    output logic [XLEN-1:0] RsData,
    output logic [XLEN-1:0] RtData,
    output logic [XLEN-1:0] PCAddrIncOut,
    output logic [AW-1:0]   RAddrOut,
    output logic [AW-1:0]   RsAddr,
    output logic [AW-1:0]   RtAddr,
    output logic            Branch,
    output logic            Jump,
    output logic            MemRead,
    output logic            MemtoReg,
    output logic            ALUOp,
    output logic            MULOp,
    output logic            MemWrite,
    output logic            ALUSrc,
    output logic            RegWriteOut,
    output logic [5:0]      ALUfunc,
    output logic [4:0]      Shamt,
    output logic [31:0]     StallCount
);
    logic [1:0]      regdst;
    logic            shiftsel, immsize, unsgnsel;
    logic            d_branch, d_jump, d_memread, d_memtoreg, d_aluop, d_mulop;
    logic            d_memwrite, d_alusrc, d_regwrite;
    logic [5:0]      d_alufunc;
    logic [14:0]     ctl_d, ctl_q;
    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   rs_addr, rt_addr, rd_addr;
    logic [XLEN-1:0] rs_val, rt_val, imm;
    logic            advance, hazard, valid_q;

    dec_ctrl u_dec (
        .opcode   (Instruction[31:26]),
        .funct    (Instruction[5:0]),
        .regdst   (regdst),
        .shiftsel (shiftsel),
        .immsize  (immsize),
        .unsgnsel (unsgnsel),
        .branch   (d_branch),
        .jump     (d_jump),
        .memread  (d_memread),
        .memtoreg (d_memtoreg),
        .aluop    (d_aluop),
        .mulop    (d_mulop),
        .memwrite (d_memwrite),
        .alusrc   (d_alusrc),
        .regwrite (d_regwrite),
        .alufunc  (d_alufunc)
    );

    assign ctl_d = {d_branch, d_jump, d_memread, d_memtoreg, d_aluop, d_mulop,
                    d_memwrite, d_alusrc, d_regwrite, d_alufunc};
    assign {Branch, Jump, MemRead, MemtoReg, ALUOp, MULOp,
            MemWrite, ALUSrc, RegWriteOut, ALUfunc} = ctl_q;
    assign OutValid = valid_q;

    assign rs_addr = AW'(Instruction[25:21]);
    assign rt_addr = AW'(Instruction[20:16]);
    assign rd_addr = regdst[1] ? AW'(5'd31) :
                     regdst[0] ? AW'(Instruction[15:11]) : AW'(Instruction[20:16]);

    always_comb begin
        imm = '0;
        if (immsize)
            imm = XLEN'(Instruction[25:0]);
        else if (shiftsel)
            imm = XLEN'($signed({Instruction[15:0], 16'h0000}));
        else if (unsgnsel)
            imm = XLEN'(Instruction[15:0]);
        else
            imm = XLEN'($signed(Instruction[15:0]));
    end

    // Reads see a same-cycle writeback so the value written this edge is never missed.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs_addr != '0)
            rs_val = (RegWriteIn && RAddrIn == rs_addr) ? RData : regs[rs_addr];
        if (rt_addr != '0)
            rt_val = (RegWriteIn && RAddrIn == rt_addr) ? RData : regs[rt_addr];
    end

    assign advance = !valid_q || OutReady;
    assign hazard  = valid_q && MemRead && RegWriteOut && (RAddrOut != '0) &&
                     ((RAddrOut == rs_addr) || (RAddrOut == rt_addr));
    assign InReady = Flush || (advance && !hazard);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (RegWriteIn && RAddrIn != '0) begin
            regs[RAddrIn] <= RData;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            valid_q      <= 1'b0;
            ctl_q        <= '0;
            ImmData      <= '0;
            RsData       <= '0;
            RtData       <= '0;
            PCAddrIncOut <= '0;
            RAddrOut     <= '0;
            RsAddr       <= '0;
            RtAddr       <= '0;
            Shamt        <= '0;
        end else if (Flush || (advance && (!InValid || hazard))) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
        end else if (advance) begin
            valid_q      <= 1'b1;
            ctl_q        <= ctl_d;
            ImmData      <= imm;
            RsData       <= rs_val;
            RtData       <= rt_val;
            PCAddrIncOut <= PCAddrIncIn;
            RAddrOut     <= rd_addr;
            RsAddr       <= rs_addr;
            RtAddr       <= rt_addr;
            Shamt        <= Instruction[10:6];
        end else if (RegWriteIn && RAddrIn != '0) begin
            // Held operands track writebacks so execute never consumes a stale value.
            if (RAddrIn == RsAddr)
                RsData <= RData;
            if (RAddrIn == RtAddr)
                RtData <= RData;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            StallCount <= '0;
        else if (advance && InValid && hazard && !Flush && StallCount != 32'hFFFF_FFFF)
            StallCount <= StallCount + 32'd1;
    end
endmodule

// File: tb/tb_dec_pipe.sv
// tb/tb_dec_pipe.sv - self-checking bench for dec_pipe against a behavioural decode model

module tb_dec_pipe;
    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        InValid, InReady, Flush, RegWriteIn, OutValid, OutReady;
    logic [31:0] Instruction, PCAddrIncIn, RData, ImmData, RsData, RtData, PCAddrIncOut;
    logic [4:0]  RAddrIn, RAddrOut, RsAddr, RtAddr, Shamt;
    logic        Branch, Jump, MemRead, MemtoReg, ALUOp, MULOp, MemWrite, ALUSrc, RegWriteOut;
    logic [5:0]  ALUfunc;
    logic [31:0] StallCount;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] pc_ctr = 32'h0000_1004;
    logic        pre_ready;

    always #5 Clock = ~Clock;

    dec_pipe #(.XLEN(32), .NREGS(32)) dut (
        .Clock(Clock), .nReset(nReset), .InValid(InValid), .InReady(InReady),
        .Instruction(Instruction), .PCAddrIncIn(PCAddrIncIn), .Flush(Flush),
        .RegWriteIn(RegWriteIn), .RAddrIn(RAddrIn), .RData(RData),
        .OutValid(OutValid), .OutReady(OutReady), .ImmData(ImmData),
        .RsData(RsData), .RtData(RtData), .PCAddrIncOut(PCAddrIncOut),
        .RAddrOut(RAddrOut), .RsAddr(RsAddr), .RtAddr(RtAddr),
        .Branch(Branch), .Jump(Jump), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .ALUOp(ALUOp), .MULOp(MULOp), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
        .RegWriteOut(RegWriteOut), .ALUfunc(ALUfunc), .Shamt(Shamt),
        .StallCount(StallCount)
    );

    typedef struct packed {
        logic        branch, jump, memread, memtoreg, aluop, mulop, memwrite, alusrc, regwrite;
        logic [5:0]  alufunc;
        logic [31:0] imm;
        logic [4:0]  rd;
    } rec_t;

    function automatic rec_t model_decode(input logic [31:0] ins);
        rec_t        r;
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        r = '0;
        r.imm = sx;
        r.rd = ins[20:16];
        case (ins[31:26])
            6'h00: begin
                r.regwrite = 1; r.aluop = 1; r.alufunc = ins[5:0]; r.rd = ins[15:11];
                r.mulop = (ins[5:0] == 6'h18) || (ins[5:0] == 6'h19);
            end
            6'h02: begin r.jump = 1; r.imm = {6'd0, ins[25:0]}; end
            6'h03: begin r.jump = 1; r.regwrite = 1; r.imm = {6'd0, ins[25:0]}; r.rd = 5'd31; end
            6'h04, 6'h05: begin r.branch = 1; r.alufunc = 6'h22; end
            6'h08: begin r.regwrite = 1; r.alusrc = 1; r.alufunc = 6'h20; end
            6'h09: begin r.regwrite = 1; r.alusrc = 1; r.alufunc = 6'h21; end
            6'h0c: begin r.regwrite = 1; r.alusrc = 1; r.alufunc = 6'h24; r.imm = zx; end
            6'h0d: begin r.regwrite = 1; r.alusrc = 1; r.alufunc = 6'h25; r.imm = zx; end
            6'h0f: begin r.regwrite = 1; r.alusrc = 1; r.alufunc = 6'h25; r.imm = {ins[15:0], 16'h0000}; end
            6'h23: begin r.memread = 1; r.memtoreg = 1; r.regwrite = 1; r.alusrc = 1; r.alufunc = 6'h20; end
            6'h2b: begin r.memwrite = 1; r.alusrc = 1; r.alufunc = 6'h20; end
            default: ;
        endcase
        return r;
    endfunction

    // Model state: what the output register and register file must hold.
    logic        m_valid;
    rec_t        m_rec;
    logic [31:0] m_rs, m_rt, m_pc, m_stall;
    logic [4:0]  m_rsa, m_rta, m_sh;
    logic [31:0] m_rf [32];
    logic        m_adv, m_hz, m_inready;

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWriteIn && RAddrIn == a) return RData;
        return m_rf[a];
    endfunction

    assign m_adv = !m_valid || OutReady;
    assign m_hz  = m_valid && m_rec.memread && m_rec.regwrite && m_rec.rd != 5'd0 &&
                   (m_rec.rd == Instruction[25:21] || m_rec.rd == Instruction[20:16]);
    assign m_inready = Flush || (m_adv && !m_hz);

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            m_valid <= 0; m_rec <= '0; m_rs <= 0; m_rt <= 0; m_pc <= 0;
            m_rsa <= 0; m_rta <= 0; m_sh <= 0; m_stall <= 0;
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
        end else begin
            if (m_adv && InValid && m_hz && !Flush && m_stall != 32'hFFFF_FFFF)
                m_stall <= m_stall + 1;
            if (Flush || (m_adv && (!InValid || m_hz))) begin
                m_valid <= 0;
                m_rec <= '0;
            end else if (m_adv) begin
                m_valid <= 1;
                m_rec <= model_decode(Instruction);
                m_rs <= rdreg(Instruction[25:21]);
                m_rt <= rdreg(Instruction[20:16]);
                m_pc <= PCAddrIncIn;
                m_rsa <= Instruction[25:21];
                m_rta <= Instruction[20:16];
                m_sh <= Instruction[10:6];
            end else if (RegWriteIn && RAddrIn != 0) begin
                if (RAddrIn == m_rsa) m_rs <= RData;
                if (RAddrIn == m_rta) m_rt <= RData;
            end
            if (RegWriteIn && RAddrIn != 0) m_rf[RAddrIn] <= RData;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (nReset) begin
            chk("inready", InReady, m_inready);
            chk("outvalid", OutValid, m_valid);
            chk("stallcount", StallCount, m_stall);
            if (m_valid) begin
                chk("immdata", ImmData, m_rec.imm);
                chk("rsdata", RsData, m_rs);
                chk("rtdata", RtData, m_rt);
                chk("pcout", PCAddrIncOut, m_pc);
                chk("addrs", {RAddrOut, RsAddr, RtAddr, Shamt}, {m_rec.rd, m_rsa, m_rta, m_sh});
                chk("controls", {Branch, Jump, MemRead, MemtoReg, ALUOp, MULOp, MemWrite, ALUSrc, RegWriteOut, ALUfunc},
                    {m_rec.branch, m_rec.jump, m_rec.memread, m_rec.memtoreg, m_rec.aluop, m_rec.mulop,
                     m_rec.memwrite, m_rec.alusrc, m_rec.regwrite, m_rec.alufunc});
            end else begin
                chk("idle_controls", {Branch, Jump, MemRead, MemWrite, RegWriteOut}, 5'd0);
            end
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic cyc(input logic v, input logic [31:0] ins, input logic fl, input logic wr,
                       input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
        InValid = v; Instruction = ins; Flush = fl; RegWriteIn = wr;
        RAddrIn = wa; RData = wd; OutReady = ordy;
        PCAddrIncIn = pc_ctr;
        pc_ctr = pc_ctr + 4;
        #2 pre_ready = InReady;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        InValid = 0; Instruction = 0; Flush = 0; RegWriteIn = 0; RAddrIn = 0;
        RData = 0; OutReady = 1; PCAddrIncIn = 0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_outvalid", OutValid, 0);
        chk("rst_stall", StallCount, 0);
        chk("rst_data", {ImmData, RsData}, 0);
        chk("rst_addr", {RAddrOut, RegWriteOut, MemRead}, 0);
        nReset = 1;
        #1 chk("rst_inready", InReady, 1);
        @(posedge Clock);
        #1;

        cyc(1, itype(6'h08, 0, 1, 16'd5), 0, 0, 0, 0, 1);
        chk("addi1", {OutValid, ImmData, RAddrOut}, {1'b1, 32'd5, 5'd1});
        cyc(1, itype(6'h08, 0, 2, 16'd7), 0, 0, 0, 0, 1);
        chk("addi2", {OutValid, ImmData, RAddrOut}, {1'b1, 32'd7, 5'd2});

        cyc(1, itype(6'h23, 1, 3, 16'd0), 0, 0, 0, 0, 1);
        chk("lw_out", {OutValid, MemRead}, 2'b11);
        cyc(1, rtype(3, 2, 4, 6'h20), 0, 0, 0, 0, 1);
        chk("hz_inready", pre_ready, 0);
        chk("hz_bubble", {OutValid, StallCount}, {1'b0, 32'd1});
        cyc(1, rtype(3, 2, 4, 6'h20), 0, 0, 0, 0, 1);
        chk("hz_accept", {pre_ready, OutValid, RAddrOut, StallCount}, {2'b11, 5'd4, 32'd1});

        cyc(1, rtype(5, 0, 6, 6'h25), 0, 1, 5, 32'hDEAD_BEEF, 1);
        chk("bypass", RsData, 32'hDEAD_BEEF);

        cyc(1, rtype(7, 0, 8, 6'h20), 0, 0, 0, 0, 1);
        cyc(1, itype(6'h0d, 0, 9, 16'h8001), 0, 0, 0, 0, 0);
        chk("hold1_ready", pre_ready, 0);
        cyc(1, itype(6'h0d, 0, 9, 16'h8001), 0, 1, 7, 32'h1234, 0);
        chk("hold2_ready", pre_ready, 0);
        cyc(1, itype(6'h0d, 0, 9, 16'h8001), 0, 0, 0, 0, 0);
        chk("hold3_ready", pre_ready, 0);
        chk("hold_refresh", {RsData, RsAddr, RAddrOut}, {32'h1234, 5'd7, 5'd8});
        cyc(1, itype(6'h0d, 0, 9, 16'h8001), 0, 0, 0, 0, 1);
        chk("ori_zext", {ImmData, RAddrOut}, {32'h0000_8001, 5'd9});

        cyc(1, itype(6'h08, 0, 10, 16'hFFFF), 1, 0, 0, 0, 1);
        chk("flush", {pre_ready, OutValid, RegWriteOut}, 3'b100);
        cyc(1, itype(6'h08, 0, 10, 16'hFFFF), 0, 0, 0, 0, 1);
        chk("addi_sext", ImmData, 32'hFFFF_FFFF);

        cyc(1, {6'h03, 26'h012_3456}, 0, 0, 0, 0, 1);
        chk("jal", {RAddrOut, ImmData, Jump}, {5'd31, 32'h0012_3456, 1'b1});
        cyc(1, itype(6'h0f, 0, 11, 16'hABCD), 0, 0, 0, 0, 1);
        chk("lui", {ImmData, RAddrOut}, {32'hABCD_0000, 5'd11});

        cyc(1, rtype(0, 0, 12, 6'h25), 0, 1, 0, 32'hFFFF, 1);
        cyc(1, rtype(0, 5, 13, 6'h18), 0, 0, 0, 0, 1);
        chk("r0_and_rf", {RsData, RtData, MULOp}, {32'd0, 32'hDEAD_BEEF, 1'b1});

        cyc(1, itype(6'h23, 1, 3, 16'd4), 0, 0, 0, 0, 1);
        cyc(1, rtype(3, 2, 4, 6'h20), 1, 0, 0, 0, 1);
        chk("hz_flush", {pre_ready, OutValid, StallCount}, {2'b10, 32'd1});
        cyc(0, 32'd0, 0, 0, 0, 0, 1);
        cyc(1, itype(6'h2b, 7, 3, 16'h0010), 0, 0, 0, 0, 1);
        chk("sw", {MemWrite, RegWriteOut, RsData}, {2'b10, 32'h1234});

        cyc(1, rtype(7, 5, 14, 6'h20), 0, 0, 0, 0, 0);
        InValid = 1; RegWriteIn = 1; RAddrIn = 5'd14; RData = 32'h5555; OutReady = 0;
        nReset = 0;
        #2 chk("rst_hold", {OutValid, StallCount, RsData}, 0);
        @(posedge Clock);
        #1 RegWriteIn = 0;
        nReset = 1;
        @(posedge Clock);
        #1;
        cyc(1, rtype(14, 7, 15, 6'h20), 0, 0, 0, 0, 1);
        chk("rst_rf", {OutValid, RsData, RtData}, {1'b1, 64'd0});
        cyc(0, 32'd0, 0, 0, 0, 0, 1);
        @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dec_pipe.md
# dec_pipe

Parametrised, registered decode stage for the five-stage core, placed between fetch and execute. Decodes one 32-bit instruction per cycle and reads the register file, which it owns. Results are captured into an output pipeline register with a valid/ready handshake on both sides. The stage adds load-use interlock (bubble insertion), flush, write-through bypass and a hazard-stall counter.

## Interface
- XLEN, 32, datapath width; must be ≥ 32.
- NREGS, 32, register count (power of 2); AW = $clog2(NREGS).
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- InValid  in  1  fetch presents an instruction.
- InReady  out  1  stage accepts the instruction this cycle.
- Instruction  in  32  instruction word.
- PCAddrIncIn  in  XLEN  PC+4 of the instruction.
- Flush  in  1  kill the held and the incoming instruction.
- RegWriteIn  in  1  writeback enable.
- RAddrIn  in  AW  writeback address.
- RData  in  XLEN  writeback data.
- OutValid  out  1  output register holds a valid instruction.
- OutReady  in  1  execute accepts the output register.
- ImmData, RsData, RtData, PCAddrIncOut  out  XLEN  registered operands.
- RAddrOut, RsAddr, RtAddr  out  AW  registered destination and source addresses.
- Branch, Jump, MemRead, MemtoReg, ALUOp, MULOp, MemWrite, ALUSrc, RegWriteOut  out  1  registered controls.
- ALUfunc  out  6  registered ALU function.
- Shamt  out  5  registered Instruction[10:6].
- StallCount  out  32  saturating count of inserted load-use bubbles.

## Operation
- Decode uses the team decoder module. Inputs are Instruction[31:26] and Instruction[5:0]. Outputs are RegDst[1:0], ShiftSel, ImmSize, Unsgnsel and the controls.
- Immediate selection, in priority order:
  - ImmSize: {0, Instruction[25:0]}.
  - ShiftSel: {Instruction[15:0], 16'd0}, upper bits sign-extended when XLEN > 32.
  - Otherwise: Instruction[15:0], sign-extended to XLEN, or zero-extended when Unsgnsel is set.
- Destination selection:
  - RegDst[1]: 31.
  - RegDst[0]: Instruction[15:11].
  - Otherwise: Instruction[20:16].
  - Result is truncated/zero-extended to AW.
- Register file: NREGS × XLEN. Register 0 reads 0 and ignores writes. Writes occur on the Clock edge when RegWriteIn = 1.
- Write-through: if RegWriteIn = 1 and RAddrIn equals the source address (≠ 0), the read returns RData in the same cycle.
- Hold refresh: while OutValid = 1 and OutReady = 0, a writeback to a held RsAddr/RtAddr (≠ 0) updates the held RsData/RtData.
- advance = !OutValid || OutReady.
- hazard = OutValid && MemRead && RegWriteOut && RAddrOut ≠ 0 && (RAddrOut == Instruction[25:21] || RAddrOut == Instruction[20:16]). The comparison is conservative: it ignores whether the field is actually used.
- InReady = Flush || (advance && !hazard).
- Next state of the output register, in priority order:
  1. Flush: OutValid ← 0. The incoming instruction is consumed and discarded.
  2. advance && InValid && !hazard: load the decoded instruction; OutValid ← 1.
  3. advance && (!InValid || hazard): load a bubble. OutValid ← 0 and all controls ← 0.
  4. Otherwise: hold.
- Whenever OutValid = 0, Branch, Jump, MemRead, MemWrite and RegWriteOut are 0.
- StallCount increments by 1 when advance && InValid && hazard && !Flush. It saturates at 0xFFFF_FFFF.

## Timing
- Reset (asynchronous, nReset = 0): every registered output is 0, including OutValid, the controls, the data/address fields and StallCount. All registers in the file are 0.
- Immediately after reset, InReady = 1.
- Latency: an instruction accepted at edge N appears with OutValid = 1 after edge N; throughput is 1 per cycle.
- Load-use: exactly one bubble is inserted. The load leaves on the bubble edge, hazard drops, and the dependent instruction is accepted the next cycle.
- Writeback data written on edge N is visible to an instruction decoded in the same cycle (bypass) and in all later cycles.
- Reset asserted mid-hold: the held instruction is lost and no writeback occurs. Writeback occurring simultaneously with Flush is still performed.

## Test plan
- Reset, then stream ADDI r1,r0,5 and ADDI r2,r0,7 with OutReady = 1 → back-to-back OutValid. ImmData is 5 then 7; RAddrOut is 1 then 2.
- LW r3,0(r1) followed by ADD r4,r3,r2 → one cycle with OutValid = 0, InReady = 0 during the hazard, ADD accepted the next cycle, StallCount = 1.
- Writeback r5 ← 0xDEAD_BEEF in the same cycle that OR r6,r5,r0 is decoded → RsData = 0xDEAD_BEEF.
- OutReady = 0 for 3 cycles while an instruction reading r7 is held, with writeback r7 ← 0x1234 during the hold → held RsData becomes 0x1234. No input is accepted during the hold.
- Flush asserted with OutValid = 1 and InValid = 1 → next cycle OutValid = 0 and RegWriteOut = 0. The incoming instruction is dropped and InReady = 1 during the flush.
- JAL and LUI 0xABCD → JAL gives RAddrOut = 31 and ImmData = Instruction[25:0]. LUI gives ImmData = 0xABCD_0000.
